// File: rtl/multi_cycle_controller.sv
// Multi-cycle RV32 control FSM: IF/ID/EX/MEM/WB sequencing plus a retired-instruction counter.
// Define MEM_HANDSHAKE_EN to add mem_ready and stall IF/MEM until the memory answers.
module multi_cycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        bcond,
`ifdef MEM_HANDSHAKE_EN
    input  logic        mem_ready,
`endif
    output logic        ir_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_phase,
    output logic        is_halted,
    output logic [2:0]  state,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ARITH = 7'b0110011;
    localparam logic [6:0] OP_ARI   = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;

    state_t      state_q, state_d;
    logic [31:0] retired_q, retired_d;
    logic        mem_done;

`ifdef MEM_HANDSHAKE_EN
    assign mem_done = mem_ready;
`else
    assign mem_done = 1'b1;
`endif

    logic       ir_write_c, i_or_d_c, mem_read_c, mem_write_c;
    logic       reg_write_c, mem_to_reg_c, pc_write_c, is_halted_c;
    logic [1:0] pc_src_c, alu_phase_c;

    logic is_load, is_store, is_arith, is_br, is_jal, is_jalr, is_ecall;

    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign is_arith = (opcode == OP_ARITH) || (opcode == OP_ARI);
    assign is_br    = (opcode == OP_BR);
    assign is_jal   = (opcode == OP_JAL);
    assign is_jalr  = (opcode == OP_JALR);
    assign is_ecall = (opcode == OP_ECALL);

    always_comb begin
        state_d      = state_q;
        ir_write_c   = 1'b0;
        i_or_d_c     = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        reg_write_c  = 1'b0;
        mem_to_reg_c = 1'b0;
        pc_write_c   = 1'b0;
        pc_src_c     = 2'd0;
        alu_phase_c  = 2'd0;
        is_halted_c  = 1'b0;
        case (state_q)
            S_IF: begin
                mem_read_c = 1'b1;
                ir_write_c = 1'b1;
                if (mem_done) state_d = S_ID;
            end
            S_ID: begin
                if (is_ecall) begin
                    state_d = S_HALT;
                end else if (is_load || is_store || is_arith ||
                             is_br || is_jal || is_jalr) begin
                    state_d = S_EX;
                end else begin
                    // Unknown opcode retires as a NOP
                    state_d    = S_IF;
                    pc_write_c = 1'b1;
                end
            end
            S_EX: begin
                if (is_load || is_store) begin
                    state_d = S_MEM;
                end else if (is_arith) begin
                    state_d     = S_WB;
                    alu_phase_c = 2'd2;
                end else if (is_jal || is_jalr) begin
                    state_d = S_WB;
                end else if (is_br) begin
                    state_d     = S_IF;
                    alu_phase_c = 2'd1;
                    pc_write_c  = 1'b1;
                    pc_src_c    = bcond ? 2'd1 : 2'd0;
                end else begin
                    state_d = S_IF;
                end
            end
            S_MEM: begin
                i_or_d_c = 1'b1;
                if (is_load) begin
                    mem_read_c = 1'b1;
                    if (mem_done) state_d = S_WB;
                end else if (is_store) begin
                    mem_write_c = 1'b1;
                    if (mem_done) begin
                        state_d    = S_IF;
                        pc_write_c = 1'b1;
                    end
                end else begin
                    state_d = S_IF;
                end
            end
            S_WB: begin
                state_d      = S_IF;
                reg_write_c  = 1'b1;
                pc_write_c   = 1'b1;
                mem_to_reg_c = is_load;
                pc_src_c     = is_jalr ? 2'd2 : (is_jal ? 2'd1 : 2'd0);
            end
            S_HALT: begin
                is_halted_c = 1'b1;
            end
            default: state_d = S_IF;
        endcase
    end

    always_comb begin
        ir_write   = ir_write_c   & ~reset;
        i_or_d     = i_or_d_c     & ~reset;
        mem_read   = mem_read_c   & ~reset;
        mem_write  = mem_write_c  & ~reset;
        reg_write  = reg_write_c  & ~reset;
        mem_to_reg = mem_to_reg_c & ~reset;
        pc_write   = pc_write_c   & ~reset;
        is_halted  = is_halted_c  & ~reset;
        pc_src     = reset ? 2'd0 : pc_src_c;
        alu_phase  = reset ? 2'd0 : alu_phase_c;
    end

    assign retired_d = retired_q + {31'd0, pc_write};
    assign state     = state_q;
    assign retired   = retired_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IF;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench for multi_cycle_controller: expected per-cycle control
// vectors are queued with the stimulus and checked as the FSM walks them.
module tb_multi_cycle_controller;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ARITH = 7'b0110011;
    localparam logic [6:0] OP_ARI   = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        bcond;
    logic        mem_ready;
    logic        ir_write, i_or_d, mem_read, mem_write;
    logic        reg_write, mem_to_reg, pc_write, is_halted;
    logic [1:0]  pc_src, alu_phase;
    logic [2:0]  state;
    logic [31:0] retired;

    always #5 clk = ~clk;

    multi_cycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .bcond      (bcond),
`ifdef MEM_HANDSHAKE_EN
        .mem_ready  (mem_ready),
`endif
        .ir_write   (ir_write),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_phase  (alu_phase),
        .is_halted  (is_halted),
        .state      (state),
        .retired    (retired)
    );

    logic [14:0] obs;
    assign obs = {state, ir_write, i_or_d, mem_read, mem_write, reg_write,
                  mem_to_reg, pc_write, pc_src, alu_phase, is_halted};

    typedef struct packed {
        logic [6:0]  op;
        logic        bc;
        logic        rdy;
        logic [14:0] ctl;
        logic [31:0] ret;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] exp_ret;
    int          total = 0;
    int          bad   = 0;

    task automatic push(input logic [6:0] op, input logic bc, input logic rdy,
                        input logic [2:0] st, input logic irw, input logic iod,
                        input logic mrd, input logic mwr, input logic rw,
                        input logic m2r, input logic pw, input logic [1:0] ps,
                        input logic [1:0] ap, input logic h);
        exp_t e;
        e.op  = op;
        e.bc  = bc;
        e.rdy = rdy;
        e.ctl = {st, irw, iod, mrd, mwr, rw, m2r, pw, ps, ap, h};
        e.ret = exp_ret;
        sbq.push_back(e);
        if (pw) exp_ret = exp_ret + 32'd1;
    endtask

    function automatic bit known_op(input logic [6:0] op);
        return op == OP_LOAD || op == OP_STORE || op == OP_ARITH ||
               op == OP_ARI || op == OP_BR || op == OP_JAL ||
               op == OP_JALR || op == OP_ECALL;
    endfunction

    task automatic push_instr(input logic [6:0] op, input logic bc,
                              input int stalls);
        push(op, bc, 1, 3'd0, 1, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        if (!known_op(op)) begin
            push(op, bc, 1, 3'd1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 0);
            return;
        end
        push(op, bc, 1, 3'd1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        case (op)
            OP_LOAD: begin
                push(op, bc, 1, 3'd2, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
                for (int i = 0; i < stalls; i++)
                    push(op, bc, 0, 3'd3, 0, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0);
                push(op, bc, 1, 3'd3, 0, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0);
                push(op, bc, 1, 3'd4, 0, 0, 0, 0, 1, 1, 1, 2'd0, 2'd0, 0);
            end
            OP_STORE: begin
                push(op, bc, 1, 3'd2, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
                for (int i = 0; i < stalls; i++)
                    push(op, bc, 0, 3'd3, 0, 1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 0);
                push(op, bc, 1, 3'd3, 0, 1, 0, 1, 0, 0, 1, 2'd0, 2'd0, 0);
            end
            OP_ARITH, OP_ARI: begin
                push(op, bc, 1, 3'd2, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 0);
                push(op, bc, 1, 3'd4, 0, 0, 0, 0, 1, 0, 1, 2'd0, 2'd0, 0);
            end
            OP_JAL: begin
                push(op, bc, 1, 3'd2, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
                push(op, bc, 1, 3'd4, 0, 0, 0, 0, 1, 0, 1, 2'd1, 2'd0, 0);
            end
            OP_JALR: begin
                push(op, bc, 1, 3'd2, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
                push(op, bc, 1, 3'd4, 0, 0, 0, 0, 1, 0, 1, 2'd2, 2'd0, 0);
            end
            OP_BR: begin
                push(op, bc, 1, 3'd2, 0, 0, 0, 0, 0, 0, 1, {1'b0, bc}, 2'd1, 0);
            end
            default: begin
                for (int i = 0; i < 12; i++)
                    push(op, bc, 1, 3'd5, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1);
            end
        endcase
    endtask

    task automatic drain(input string name);
        exp_t e;
        int   cyc = 0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            opcode    = e.op;
            bcond     = e.bc;
            mem_ready = e.rdy;
            #1;
            total++;
            if (obs !== e.ctl) begin
                bad++;
                $display("FAIL %s cyc%0d ctl got=%h want=%h", name, cyc, obs, e.ctl);
            end
            total++;
            if (retired !== e.ret) begin
                bad++;
                $display("FAIL %s cyc%0d retired got=%h want=%h", name, cyc, retired, e.ret);
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        opcode    = OP_ARITH;
        bcond     = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (obs !== 15'd0) begin
            bad++;
            $display("FAIL reset_ctl got=%h want=%h", obs, 15'd0);
        end
        total++;
        if (retired !== 32'd0) begin
            bad++;
            $display("FAIL reset_retired got=%h want=0", retired);
        end
        reset   = 1'b0;
        exp_ret = 32'd0;
    endtask

    task automatic test_arith();
        push_instr(OP_ARITH, 0, 0);
        drain("arith");
        push_instr(OP_ARI, 0, 0);
        drain("arith_imm");
    endtask

    task automatic test_branch();
        push_instr(OP_BR, 1, 0);
        drain("branch_taken");
        push_instr(OP_BR, 0, 0);
        drain("branch_not_taken");
    endtask

    task automatic test_mem();
        push_instr(OP_LOAD, 0, 0);
        drain("load");
        push_instr(OP_STORE, 0, 0);
        drain("store");
    endtask

    task automatic test_jumps();
        push_instr(OP_JAL, 0, 0);
        drain("jal");
        push_instr(OP_JALR, 1, 0);
        drain("jalr");
    endtask

    task automatic test_undefined();
        push_instr(7'b0000000, 0, 0);
        drain("undef_zero");
        push_instr(7'b1111111, 1, 0);
        drain("undef_ones");
    endtask

    task automatic test_back_to_back();
        push_instr(OP_LOAD, 0, 0);
        push_instr(OP_BR, 1, 0);
        push_instr(OP_ARI, 0, 0);
        push_instr(OP_STORE, 1, 0);
        push_instr(OP_JALR, 0, 0);
        push_instr(OP_BR, 0, 0);
        drain("back_to_back");
    endtask

`ifdef MEM_HANDSHAKE_EN
    task automatic test_mem_stall();
        int start_n;
        start_n = sbq.size();
        push_instr(OP_LOAD, 0, 3);
        total++;
        if (sbq.size() - start_n != 8) begin
            bad++;
            $display("FAIL stall_latency got=%0d want=8", sbq.size() - start_n);
        end
        drain("load_stall");
        push_instr(OP_STORE, 0, 2);
        drain("store_stall");
    endtask
`endif

    task automatic test_halt_reset();
        push_instr(OP_ECALL, 0, 0);
        drain("halt");
        reset = 1'b1;
        #1;
        total++;
        if (is_halted !== 1'b0 || state !== 3'd5) begin
            bad++;
            $display("FAIL halt_reset_hold got=%b/%0d want=0/5", is_halted, state);
        end
        @(negedge clk);
        total++;
        if (state !== 3'd0 || retired !== 32'd0 || is_halted !== 1'b0) begin
            bad++;
            $display("FAIL halt_reset_exit got=%0d/%h/%b want=0/0/0", state, retired, is_halted);
        end
        reset   = 1'b0;
        exp_ret = 32'd0;
        push_instr(OP_ARITH, 0, 0);
        drain("after_halt");
    endtask

    task automatic test_reset_mid_store();
        push(OP_STORE, 0, 1, 3'd0, 1, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        push(OP_STORE, 0, 1, 3'd1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        push(OP_STORE, 0, 1, 3'd2, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
        drain("store_pre_mem");
        mem_ready = 1'b0;
        reset     = 1'b1;
        #1;
        total++;
        if (state !== 3'd3 || mem_write !== 1'b0 || pc_write !== 1'b0) begin
            bad++;
            $display("FAIL rst_mem_hold got=%0d/%b/%b want=3/0/0", state, mem_write, pc_write);
        end
        @(negedge clk);
        total++;
        if (state !== 3'd0 || retired !== 32'd0 || mem_write !== 1'b0) begin
            bad++;
            $display("FAIL rst_mem_exit got=%0d/%h/%b want=0/0/0", state, retired, mem_write);
        end
        reset     = 1'b0;
        mem_ready = 1'b1;
        exp_ret   = 32'd0;
    endtask

    task automatic test_retired_wrap();
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        exp_ret = 32'hFFFF_FFFF;
        push_instr(OP_ARITH, 0, 0);
        drain("wrap");
        #1;
        total++;
        if (retired !== 32'd0) begin
            bad++;
            $display("FAIL wrap_zero got=%h want=0", retired);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_arith();
        test_branch();
        test_mem();
        test_jumps();
        test_undefined();
        test_back_to_back();
`ifdef MEM_HANDSHAKE_EN
        test_mem_stall();
`endif
        test_halt_reset();
        test_reset_mid_store();
        test_retired_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 opcode  input  7  instruction[6:0] from the instruction register (IR), stable from the cycle after IF completes.
REQ-004 bcond  input  1  branch-condition result from the ALU, valid in EX.
REQ-005 mem_ready  input  1  memory access complete; present only when MEM_HANDSHAKE_EN is defined.
REQ-006 ir_write  output  1  latch memory data into IR.
REQ-007 i_or_d  output  1  memory address select: 0 = PC, 1 = ALU output register.
REQ-008 mem_read / mem_write  output  1 each  memory strobes.
REQ-009 reg_write  output  1  register-file write enable.
REQ-010 mem_to_reg  output  1  write-back data select: 0 = ALU/PC+4, 1 = memory data register (MDR).
REQ-011 pc_write  output  1  PC update enable.
REQ-012 pc_src  output  2  next-PC select: 0 = PC+4, 1 = PC+imm, 2 = ALU result.
REQ-013 alu_phase  output  2  ALU operation class: 0 = add, 1 = compare, 2 = funct-decoded.
REQ-014 is_halted  output  1  sticky halt flag.
REQ-015 state  output  3  current state, for debug.
REQ-016 retired  output  32  count of completed instructions.

Function
REQ-017 State encoding SHALL be: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5; codes 6–7 SHALL go to IF on the next edge.
REQ-018 Opcodes SHALL be decoded as: LOAD 0000011, STORE 0100011, ARITH 0110011, ARITH_IMM 0010011, BRANCH 1100011, JAL 1101111, JALR 1100111, ECALL 1110011.
REQ-019 IF: mem_read=1, i_or_d=0, ir_write=1; advance to ID when the access completes.
REQ-020 ID: no strobes; ECALL→HALT; any undefined opcode→IF, with pc_write=1 and pc_src=0 (executed as a NOP, counted as retired); all others→EX.
REQ-021 EX next state: LOAD/STORE→MEM (alu_phase=0); ARITH/ARITH_IMM→WB (alu_phase=2); JAL/JALR→WB (alu_phase=0); BRANCH→IF.
REQ-022 EX for BRANCH: alu_phase=1, pc_write=1, pc_src=1 if bcond else 0.
REQ-023 MEM: i_or_d=1; LOAD asserts mem_read and goes to WB on completion; STORE asserts mem_write and goes to IF on completion with pc_write=1, pc_src=0.
REQ-024 WB: reg_write=1, pc_write=1, next state IF.
REQ-025 WB for LOAD: mem_to_reg=1, pc_src=0.
REQ-026 WB for ARITH/ARITH_IMM: mem_to_reg=0, pc_src=0.
REQ-027 WB for JAL: pc_src=1. WB for JALR: pc_src=2. Both write PC+4 to rd with mem_to_reg=0.
REQ-028 All outputs SHALL be combinational from state, opcode and bcond only; every output not listed for a state SHALL be 0.
REQ-029 Latency in cycles, without stalls: LOAD 5; STORE, ARITH, ARITH_IMM, JAL, JALR 4; BRANCH 3.
REQ-030 retired SHALL increment by 1 on every cycle in which pc_write=1, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-031 HALT is absorbing: is_halted=1, all strobes 0, retired frozen; only reset exits HALT.

Reset
REQ-032 reset high at an edge SHALL force state=IF and retired=0, overriding any in-progress transition in any state, including HALT and a stalled MEM.
REQ-033 While reset is high, all strobe and enable outputs SHALL be forced to 0 and is_halted SHALL be 0.

Configuration
REQ-034 With MEM_HANDSHAKE_EN defined: IF and MEM SHALL hold, with strobes held asserted, until a cycle with mem_ready=1; the transition and any pc_write SHALL occur only in that cycle.
REQ-035 With MEM_HANDSHAKE_EN undefined: the mem_ready port SHALL be absent and every memory access completes in exactly 1 cycle.

Verification
REQ-036 reset for 2 cycles, then opcode=0110011 -> states IF,ID,EX,WB,IF; reg_write=1 only in WB; retired=1.
REQ-037 opcode=1100011, bcond=1 -> EX shows pc_write=1, pc_src=1; retired=1 after 3 cycles; then bcond=0 -> pc_src=0.
REQ-038 LOAD with MEM_HANDSHAKE_EN, mem_ready low for 3 MEM cycles -> MEM held 4 cycles with mem_read=1; total latency 8 cycles.
REQ-039 opcode=1110011 -> HALT after ID, is_halted=1 for 10+ cycles, retired unchanged; reset -> state=IF, is_halted=0.
REQ-040 reset asserted during STORE MEM -> next state IF, mem_write=0, retired=0.
REQ-041 retired preloaded to 0xFFFFFFFF, then ARITH -> retired=0 after WB.
